rv32v_vcfg_tracker: RTL and testbench

- Speculative vector-configuration tracker in decode/execute; implements the shadow side of the vector shadow-CSR path.
- Computes vl/vtype for vsetvl-class instructions at execute and presents the youngest speculative config to decode.
- Buffers in-flight configs in order until mem retires them; restores architectural state on flush.

---
 rtl/rv32v_types_pkg.sv | 60 ++++++
 rtl/rv32v_vl_calc.sv | 62 ++++++
 rtl/rv32v_vcfg_tracker.sv | 156 +++++++++++++++
 tb/tb_rv32v_vcfg_tracker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32v_types_pkg.sv
// ============================================================================
// rv32v_types_pkg : vtype/vl encodings and legality helper for the vcfg path
// Rev 1.0
// ============================================================================
`default_nettype none

package rv32v_types_pkg;

    localparam int ELEN = 32;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        SEW8  = 3'b000,
        SEW16 = 3'b001,
        SEW32 = 3'b010,
        SEW64 = 3'b011
    } vsew_t;

    typedef enum logic [2:0] {
        LMUL1    = 3'b000,
        LMUL2    = 3'b001,
        LMUL4    = 3'b010,
        LMUL8    = 3'b011,
        LMUL_RSV = 3'b100,
        MF8      = 3'b101,
        MF4      = 3'b110,
        MF2      = 3'b111
    } vlmul_t;

    typedef struct packed {
        logic   vill;
        logic   vma;
        logic   vta;
        vsew_t  vsew;
        vlmul_t vlmul;
    } vtype_t;

    typedef struct packed {
        vtype_t vtype;
        word_t  vl;
    } vcfg_entry_t;

    // A requested vill bit is a reserved encoding and is treated as illegal.
    function automatic logic vtype_legal(input vtype_t vt);
        logic ok;
        ok = !vt.vill && ((32'd8 << vt.vsew) <= 32'(ELEN));
        case (vt.vlmul)
            LMUL_RSV: ok = 1'b0;
            MF8:      ok = 1'b0;
            MF4:      if (vt.vsew != SEW8) ok = 1'b0;
            MF2:      if (vt.vsew > SEW16) ok = 1'b0;
            default:  ;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32v_vl_calc.sv
// ============================================================================
// rv32v_vl_calc : combinational vtype legality, VLMAX and vl computation
// Rev 1.0
// ============================================================================
`default_nettype none

module rv32v_vl_calc
    import rv32v_types_pkg::*;
#(
    parameter int VLEN = 128
) (
    input  vtype_t     vtype_req,
    input  word_t      avl,
    input  logic       keepvl,
    input  logic       setmax,
    input  word_t      vl_cur,
    output vtype_t     vtype_res,
    output word_t      vl_res
);

    logic [3:0] sew_sh;
    word_t      base;
    word_t      vlmax;

    always_comb begin
        sew_sh = 4'd3 + {1'b0, vtype_req.vsew};
        base   = word_t'(VLEN) >> sew_sh;
        case (vtype_req.vlmul)
            LMUL2:   vlmax = base << 1;
            LMUL4:   vlmax = base << 2;
            LMUL8:   vlmax = base << 3;
            MF2:     vlmax = base >> 1;
            MF4:     vlmax = base >> 2;
            MF8:     vlmax = base >> 3;
            default: vlmax = base;
        endcase

        vtype_res      = '0;
        vtype_res.vill = 1'b1;
        vl_res         = '0;
        if (vtype_legal(vtype_req)) begin
            vtype_res      = vtype_req;
            vtype_res.vill = 1'b0;
            if (setmax) begin
                vl_res = vlmax;
            end else if (keepvl) begin
                // Keeping vl under a smaller VLMAX makes the config illegal.
                if (vl_cur <= vlmax) begin
                    vl_res = vl_cur;
                end else begin
                    vtype_res      = '0;
                    vtype_res.vill = 1'b1;
                end
            end else begin
                vl_res = (avl < vlmax) ? avl : vlmax;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv32v_vcfg_tracker.sv
// ============================================================================
// rv32v_vcfg_tracker : speculative vl/vtype shadow plus in-order vsetvl buffer
// Optional counters: RV32V_VCFG_PERF_EN. Rev 1.0
// ============================================================================
`default_nettype none

module rv32v_vcfg_tracker
    import rv32v_types_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      flush_decode,
    input  logic                      cfg_valid,
    input  logic                      cfg_keepvl,
    input  logic                      cfg_setmax,
    input  vtype_t                    cfg_vtype,
    input  logic [31:0]               cfg_avl,
    output logic [31:0]               cfg_vl_result,
    output logic                      cfg_full,
    input  logic                      commit_ready,
    output logic                      commit_valid,
    output vtype_t                    commit_vtype,
    output logic [31:0]               commit_vl,
    input  vtype_t                    vtype_arch,
    input  logic [31:0]               vl_arch,
    output vlmul_t                    vlmul_shadow,
    output vsew_t                     vsew_shadow,
    output logic                      vill_shadow,
    output logic [31:0]               vl_shadow,
    output logic [$clog2(DEPTH):0]    inflight_cnt
`ifdef RV32V_VCFG_PERF_EN
    ,
    output logic [31:0]               perf_cfg_cnt,
    output logic [31:0]               perf_squash_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    vcfg_entry_t          entry_q [DEPTH];
    vcfg_entry_t          entry_d [DEPTH];
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    vcfg_entry_t          shadow_q, shadow_d;

    vtype_t               calc_vtype;
    word_t                calc_vl;
    logic                 push;
    logic                 pop;

    rv32v_vl_calc #(.VLEN(VLEN)) u_vl_calc (
        .vtype_req (cfg_vtype),
        .avl       (cfg_avl),
        .keepvl    (cfg_keepvl),
        .setmax    (cfg_setmax),
        .vl_cur    (shadow_q.vl),
        .vtype_res (calc_vtype),
        .vl_res    (calc_vl)
    );

    assign cfg_full      = (cnt_q == CW'(DEPTH));
    assign pop           = commit_ready && (cnt_q != '0);
    assign push          = cfg_valid && (!cfg_full || commit_ready) && !flush_decode;

    always_comb begin
        entry_d  = entry_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;

        if (push) begin
            entry_d[tail_q] = '{vtype: calc_vtype, vl: calc_vl};
            tail_d          = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end

        if (flush_decode) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            // The CSR file only absorbs a retiring vsetvl next cycle.
            shadow_d = pop ? entry_q[head_q] : '{vtype: vtype_arch, vl: vl_arch};
        end else begin
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            if (push) begin
                shadow_d = '{vtype: calc_vtype, vl: calc_vl};
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            entry_q             <= '{default: '0};
            head_q              <= '0;
            tail_q              <= '0;
            cnt_q               <= '0;
            shadow_q            <= '0;
            shadow_q.vtype.vill <= 1'b1;
        end else begin
            entry_q  <= entry_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign cfg_vl_result = calc_vl;
    assign commit_valid  = (cnt_q != '0);
    assign commit_vtype  = entry_q[head_q].vtype;
    assign commit_vl     = entry_q[head_q].vl;
    assign vlmul_shadow  = shadow_q.vtype.vlmul;
    assign vsew_shadow   = shadow_q.vtype.vsew;
    assign vill_shadow   = shadow_q.vtype.vill;
    assign vl_shadow     = shadow_q.vl;
    assign inflight_cnt  = cnt_q;

`ifdef RV32V_VCFG_PERF_EN
    logic [31:0] perf_cfg_q, perf_cfg_d;
    logic [31:0] perf_squash_q, perf_squash_d;

    always_comb begin
        perf_cfg_d    = perf_cfg_q + 32'(push);
        perf_squash_d = perf_squash_q;
        if (flush_decode) begin
            perf_squash_d = perf_squash_q + 32'(cnt_q) - 32'(pop);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_cfg_q    <= '0;
            perf_squash_q <= '0;
        end else begin
            perf_cfg_q    <= perf_cfg_d;
            perf_squash_q <= perf_squash_d;
        end
    end

    assign perf_cfg_cnt    = perf_cfg_q;
    assign perf_squash_cnt = perf_squash_q;
`else
    // Counters absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv32v_vcfg_tracker.sv
// ============================================================================
// tb_rv32v_vcfg_tracker : vector table plus scoreboard of in-flight configs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rv32v_vcfg_tracker;
    import rv32v_types_pkg::*;

    localparam int VLEN  = 128;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush_decode = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_keepvl = 1'b0;
    logic        cfg_setmax = 1'b0;
    vtype_t      cfg_vtype = '0;
    logic [31:0] cfg_avl = '0;
    logic [31:0] cfg_vl_result;
    logic        cfg_full;
    logic        commit_ready = 1'b0;
    logic        commit_valid;
    vtype_t      commit_vtype;
    logic [31:0] commit_vl;
    vtype_t      vtype_arch = '0;
    logic [31:0] vl_arch = '0;
    vlmul_t      vlmul_shadow;
    vsew_t       vsew_shadow;
    logic        vill_shadow;
    logic [31:0] vl_shadow;
    logic [$clog2(DEPTH):0] inflight_cnt;
`ifdef RV32V_VCFG_PERF_EN
    logic [31:0] perf_cfg_cnt;
    logic [31:0] perf_squash_cnt;
`endif

    rv32v_vcfg_tracker #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .flush_decode  (flush_decode),
        .cfg_valid     (cfg_valid),
        .cfg_keepvl    (cfg_keepvl),
        .cfg_setmax    (cfg_setmax),
        .cfg_vtype     (cfg_vtype),
        .cfg_avl       (cfg_avl),
        .cfg_vl_result (cfg_vl_result),
        .cfg_full      (cfg_full),
        .commit_ready  (commit_ready),
        .commit_valid  (commit_valid),
        .commit_vtype  (commit_vtype),
        .commit_vl     (commit_vl),
        .vtype_arch    (vtype_arch),
        .vl_arch       (vl_arch),
        .vlmul_shadow  (vlmul_shadow),
        .vsew_shadow   (vsew_shadow),
        .vill_shadow   (vill_shadow),
        .vl_shadow     (vl_shadow),
        .inflight_cnt  (inflight_cnt)
`ifdef RV32V_VCFG_PERF_EN
        ,
        .perf_cfg_cnt    (perf_cfg_cnt),
        .perf_squash_cnt (perf_squash_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  sew;
        logic [2:0]  lmul;
        logic        vta;
        logic        vma;
        logic [31:0] avl;
        logic        keep;
        logic        smax;
        logic [31:0] evl;
        logic        evill;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    vcfg_entry_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vtype_t mk_vt(input logic [2:0] sew, input logic [2:0] lmul,
                                     input logic vta, input logic vma);
        vtype_t v;
        v.vill  = 1'b0;
        v.vma   = vma;
        v.vta   = vta;
        v.vsew  = vsew_t'(sew);
        v.vlmul = vlmul_t'(lmul);
        return v;
    endfunction

    function automatic vcfg_entry_t e8(input logic [31:0] vl);
        vcfg_entry_t e;
        e.vtype = mk_vt(3'd0, 3'd0, 1'b0, 1'b0);
        e.vl    = vl;
        return e;
    endfunction

    task automatic idle_inputs();
        cfg_valid    = 1'b0;
        cfg_keepvl   = 1'b0;
        cfg_setmax   = 1'b0;
        commit_ready = 1'b0;
        flush_decode = 1'b0;
    endtask

    task automatic drive_e8(input logic [31:0] avl);
        cfg_valid = 1'b1;
        cfg_vtype = mk_vt(3'd0, 3'd0, 1'b0, 1'b0);
        cfg_avl   = avl;
    endtask

    // One clock: checks combinational outputs, updates the scoreboard, then advances.
    task automatic step(input vcfg_entry_t exp_e);
        logic do_pop;
        logic do_push;
        #1;
        chk("commit_valid", 32'(commit_valid), 32'(exp_q.size() != 0));
        if (cfg_valid) chk("cfg_vl_result", cfg_vl_result, exp_e.vl);
        do_pop  = commit_ready && (exp_q.size() != 0);
        do_push = cfg_valid && !flush_decode && ((exp_q.size() < DEPTH) || commit_ready);
        if (do_pop) begin
            chk("commit_vl", commit_vl, exp_q[0].vl);
            chk("commit_vtype", 32'(commit_vtype), 32'(exp_q[0].vtype));
            void'(exp_q.pop_front());
        end
        if (flush_decode) exp_q.delete();
        else if (do_push) exp_q.push_back(exp_e);
        @(posedge CLK);
        #1;
        idle_inputs();
        chk("inflight_cnt", 32'(inflight_cnt), 32'(exp_q.size()));
        chk("cfg_full", 32'(cfg_full), 32'(exp_q.size() == DEPTH));
    endtask

    task automatic chk_shadow(input string name, input vcfg_entry_t e);
        chk({name, "_vl"},    vl_shadow, e.vl);
        chk({name, "_vill"},  32'(vill_shadow), 32'(e.vtype.vill));
        chk({name, "_vsew"},  32'(vsew_shadow), 32'(e.vtype.vsew));
        chk({name, "_vlmul"}, 32'(vlmul_shadow), 32'(e.vtype.vlmul));
    endtask

    vec_t vecs[15];

    initial begin
        vcfg_entry_t ex;
        vcfg_entry_t rst_e;
        vcfg_entry_t dummy;

        vecs[0]  = '{3'd2, 3'd0, 1'b0, 1'b0, 32'd10,  1'b0, 1'b0, 32'd4,   1'b0};
        vecs[1]  = '{3'd0, 3'd3, 1'b0, 1'b0, 32'd100, 1'b0, 1'b0, 32'd100, 1'b0};
        vecs[2]  = '{3'd0, 3'd5, 1'b1, 1'b1, 32'd5,   1'b0, 1'b0, 32'd0,   1'b1};
        vecs[3]  = '{3'd1, 3'd1, 1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd16,  1'b0};
        vecs[4]  = '{3'd1, 3'd7, 1'b0, 1'b0, 32'd3,   1'b0, 1'b0, 32'd3,   1'b0};
        vecs[5]  = '{3'd2, 3'd7, 1'b0, 1'b0, 32'd3,   1'b0, 1'b0, 32'd0,   1'b1};
        vecs[6]  = '{3'd0, 3'd6, 1'b0, 1'b0, 32'd50,  1'b0, 1'b0, 32'd4,   1'b0};
        vecs[7]  = '{3'd3, 3'd0, 1'b0, 1'b0, 32'd5,   1'b0, 1'b0, 32'd0,   1'b1};
        vecs[8]  = '{3'd0, 3'd0, 1'b0, 1'b0, 32'd8,   1'b0, 1'b0, 32'd8,   1'b0};
        vecs[9]  = '{3'd2, 3'd0, 1'b0, 1'b0, 32'd1,   1'b1, 1'b0, 32'd0,   1'b1};
        vecs[10] = '{3'd1, 3'd2, 1'b0, 1'b0, 32'd0,   1'b0, 1'b0, 32'd0,   1'b0};
        vecs[11] = '{3'd0, 3'd1, 1'b1, 1'b1, 32'd30,  1'b0, 1'b0, 32'd30,  1'b0};
        vecs[12] = '{3'd1, 3'd2, 1'b0, 1'b0, 32'd2,   1'b1, 1'b0, 32'd30,  1'b0};
        vecs[13] = '{3'd0, 3'd4, 1'b0, 1'b0, 32'd5,   1'b0, 1'b0, 32'd0,   1'b1};
        vecs[14] = '{3'd0, 3'd3, 1'b0, 1'b0, 32'd1,   1'b0, 1'b1, 32'd128, 1'b0};

        rst_e = '0;
        rst_e.vtype.vill = 1'b1;
        dummy = '0;

        repeat (3) @(posedge CLK);
        #1;
        chk_shadow("reset", rst_e);
        chk("reset_cnt", 32'(inflight_cnt), 32'd0);
        chk("reset_commit_valid", 32'(commit_valid), 32'd0);
        chk("reset_full", 32'(cfg_full), 32'd0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 15; i++) begin
            cfg_valid  = 1'b1;
            cfg_vtype  = mk_vt(vecs[i].sew, vecs[i].lmul, vecs[i].vta, vecs[i].vma);
            cfg_avl    = vecs[i].avl;
            cfg_keepvl = vecs[i].keep;
            cfg_setmax = vecs[i].smax;
            if (vecs[i].evill) begin
                ex = '0;
                ex.vtype.vill = 1'b1;
            end else begin
                ex.vtype = cfg_vtype;
                ex.vl    = vecs[i].evl;
            end
            step(ex);
            chk_shadow($sformatf("vec%0d", i), ex);
            commit_ready = 1'b1;
            step(dummy);
        end

        // Fill to DEPTH, drop a push at full, then push-with-pop at full.
        for (int i = 1; i <= DEPTH; i++) begin
            drive_e8(32'(i));
            step(e8(32'(i)));
        end
        chk("full_flag", 32'(cfg_full), 32'd1);
        drive_e8(32'd5);
        step(e8(32'd5));
        chk("dropped_push_vl_shadow", vl_shadow, 32'd4);
        drive_e8(32'd6);
        commit_ready = 1'b1;
        step(e8(32'd6));
        chk("full_pushpop_vl_shadow", vl_shadow, 32'd6);
        for (int i = 0; i < DEPTH; i++) begin
            commit_ready = 1'b1;
            step(dummy);
        end

        // Flush restores architectural config; the same-cycle push is discarded.
        drive_e8(32'd3); step(e8(32'd3));
        drive_e8(32'd5); step(e8(32'd5));
        vl_arch    = 32'd7;
        vtype_arch = mk_vt(3'd1, 3'd0, 1'b0, 1'b0);
        drive_e8(32'd9);
        flush_decode = 1'b1;
        step(e8(32'd9));
        ex.vtype = vtype_arch;
        ex.vl    = 32'd7;
        chk_shadow("flush_arch", ex);

        // Flush with a coincident pop reloads from the retiring entry.
        drive_e8(32'd3); step(e8(32'd3));
        drive_e8(32'd5); step(e8(32'd5));
        flush_decode = 1'b1;
        commit_ready = 1'b1;
        step(dummy);
        chk_shadow("flush_pop", e8(32'd3));

        commit_ready = 1'b1;
        step(dummy);

        // Asynchronous reset in the middle of activity.
        drive_e8(32'd2); step(e8(32'd2));
        drive_e8(32'd3); step(e8(32'd3));
        #2;
        nRST = 1'b0;
        #1;
        exp_q.delete();
        chk("async_rst_cnt", 32'(inflight_cnt), 32'd0);
        chk("async_rst_commit_valid", 32'(commit_valid), 32'd0);
        chk_shadow("async_rst", rst_e);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        drive_e8(32'd1); step(e8(32'd1));
        drive_e8(32'd2); step(e8(32'd2));
        drive_e8(32'd3); step(e8(32'd3));
        commit_ready = 1'b1;
        step(dummy);
        flush_decode = 1'b1;
        step(dummy);
`ifdef RV32V_VCFG_PERF_EN
        chk("perf_cfg_cnt", perf_cfg_cnt, 32'd3);
        chk("perf_squash_cnt", perf_squash_cnt, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
